// File: rtl/reg_read_stage.sv
// Register-read stage: reads the PRF, merges writeback bypasses, and buffers up to two uops
// (HEAD + SKID) under FU back-pressure while refreshing their operands from the bypass bus.
module reg_read_stage #(
  parameter int NUM_PREGS = 64,
  parameter int PREG_W    = 6,
  parameter int NUM_BYP   = 3,
  parameter int OP_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_en,
  input  logic                      iss_valid,
  output logic                      iss_ready,
  input  logic [PREG_W-1:0]         iss_src1_reg,
  input  logic [PREG_W-1:0]         iss_src2_reg,
  input  logic [PREG_W-1:0]         iss_dst_reg,
  input  logic [OP_W-1:0]           iss_op,
  output logic [PREG_W-1:0]         rf_src1_reg,
  output logic [PREG_W-1:0]         rf_src2_reg,
  input  logic [31:0]               rf_src1_val,
  input  logic [31:0]               rf_src2_val,
  input  logic [NUM_BYP-1:0]        byp_valid,
  input  logic [NUM_BYP*PREG_W-1:0] byp_dst_reg,
  input  logic [NUM_BYP*32-1:0]     byp_val,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [31:0]               ex_src1_val,
  output logic [31:0]               ex_src2_val,
  output logic [PREG_W-1:0]         ex_dst_reg,
  output logic [OP_W-1:0]           ex_op
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PREG_W-1:0] src1;
    logic [PREG_W-1:0] src2;
    logic [PREG_W-1:0] dst;
    logic [31:0]       val1;
    logic [31:0]       val2;
    logic [OP_W-1:0]   op;
  } entry_t;

  state_t state, state_nx;
  entry_t head, skid, head_nx, skid_nx;
  entry_t cap, head_snp, skid_snp;
  logic   accept, pop;

  // p0 is hardwired zero; otherwise the lowest-indexed matching bypass wins over the fallback.
  function automatic logic [31:0] resolve(
    input logic [PREG_W-1:0]         idx,
    input logic [31:0]               fallback,
    input logic [NUM_BYP-1:0]        bv,
    input logic [NUM_BYP*PREG_W-1:0] bd,
    input logic [NUM_BYP*32-1:0]     bval
  );
    logic [31:0] r;
    int unsigned k;
    r = fallback;
    for (int unsigned i = 0; i < NUM_BYP; i++) begin
      k = NUM_BYP - 1 - i;
      if (bv[k] && (bd[k*PREG_W +: PREG_W] == idx)) r = bval[k*32 +: 32];
    end
    if (idx == '0) r = '0;
    return r;
  endfunction

  function automatic entry_t snoop(
    input entry_t                    e,
    input logic [NUM_BYP-1:0]        bv,
    input logic [NUM_BYP*PREG_W-1:0] bd,
    input logic [NUM_BYP*32-1:0]     bval
  );
    entry_t r;
    r      = e;
    r.val1 = resolve(e.src1, e.val1, bv, bd, bval);
    r.val2 = resolve(e.src2, e.val2, bv, bd, bval);
    return r;
  endfunction

  assign rf_src1_reg = iss_src1_reg;
  assign rf_src2_reg = iss_src2_reg;

  assign iss_ready = (state != S_FULL) && rst;
  assign ex_valid  = (state != S_EMPTY);
  assign accept    = iss_valid && iss_ready && !flush_en;
  assign pop       = ex_valid && ex_ready;

  assign ex_src1_val = head.val1;
  assign ex_src2_val = head.val2;
  assign ex_dst_reg  = head.dst;
  assign ex_op       = head.op;

  always_comb begin
    cap.src1 = iss_src1_reg;
    cap.src2 = iss_src2_reg;
    cap.dst  = iss_dst_reg;
    cap.op   = iss_op;
    cap.val1 = resolve(iss_src1_reg, rf_src1_val, byp_valid, byp_dst_reg, byp_val);
    cap.val2 = resolve(iss_src2_reg, rf_src2_val, byp_valid, byp_dst_reg, byp_val);
    head_snp = snoop(head, byp_valid, byp_dst_reg, byp_val);
    skid_snp = snoop(skid, byp_valid, byp_dst_reg, byp_val);
  end

  always_comb begin
    state_nx = state;
    head_nx  = (state != S_EMPTY) ? head_snp : head;
    skid_nx  = (state == S_FULL)  ? skid_snp : skid;
    case (state)
      S_EMPTY: begin
        if (accept) begin
          head_nx  = cap;
          state_nx = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && pop) begin
          head_nx = cap;
        end else if (accept) begin
          skid_nx  = cap;
          state_nx = S_FULL;
        end else if (pop) begin
          state_nx = S_EMPTY;
        end
      end
      S_FULL: begin
        // SKID promotes with this cycle's bypass already merged in.
        if (pop) begin
          head_nx  = skid_snp;
          state_nx = S_ONE;
        end
      end
      default: state_nx = S_EMPTY;
    endcase
    if (flush_en) state_nx = S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_nx;
      head  <= head_nx;
      skid  <= skid_nx;
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed scenarios plus random traffic against a queue-based
// model of the in-order buffer, with the PRF modelled as an array behind the read port.
module tb_reg_read_stage;
  localparam int NP = 64;
  localparam int PW = 6;
  localparam int NB = 3;
  localparam int OW = 32;

  logic           clk = 1'b0;
  logic           rst, flush_en, iss_valid, iss_ready, ex_valid, ex_ready;
  logic [PW-1:0]  iss_src1_reg, iss_src2_reg, iss_dst_reg, rf_src1_reg, rf_src2_reg, ex_dst_reg;
  logic [OW-1:0]  iss_op, ex_op;
  logic [31:0]    rf_src1_val, rf_src2_val, ex_src1_val, ex_src2_val;
  logic [NB-1:0]  byp_valid;
  logic [NB*PW-1:0] byp_dst_reg;
  logic [NB*32-1:0] byp_val;

  logic [31:0] prf [NP];

  typedef struct {
    logic [PW-1:0] s1, s2, dst;
    logic [31:0]   v1, v2;
    logic [OW-1:0] op;
  } uop_t;

  uop_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  assign rf_src1_val = prf[rf_src1_reg];
  assign rf_src2_val = prf[rf_src2_reg];

  reg_read_stage #(.NUM_PREGS(NP), .PREG_W(PW), .NUM_BYP(NB), .OP_W(OW)) dut (
    .clk(clk), .rst(rst), .flush_en(flush_en),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_src1_reg(iss_src1_reg), .iss_src2_reg(iss_src2_reg), .iss_dst_reg(iss_dst_reg),
    .iss_op(iss_op),
    .rf_src1_reg(rf_src1_reg), .rf_src2_reg(rf_src2_reg),
    .rf_src1_val(rf_src1_val), .rf_src2_val(rf_src2_val),
    .byp_valid(byp_valid), .byp_dst_reg(byp_dst_reg), .byp_val(byp_val),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_src1_val(ex_src1_val), .ex_src2_val(ex_src2_val),
    .ex_dst_reg(ex_dst_reg), .ex_op(ex_op)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Value a source index reads right now: zero for p0, else first matching bypass, else fallback.
  function automatic logic [31:0] model_val(input logic [PW-1:0] idx, input logic [31:0] fb);
    if (idx == 0) return 32'h0;
    for (int k = 0; k < NB; k++)
      if (byp_valid[k] && byp_dst_reg[k*PW +: PW] == idx) return byp_val[k*32 +: 32];
    return fb;
  endfunction

  task automatic idle();
    iss_valid   = 1'b0;
    flush_en    = 1'b0;
    byp_valid   = '0;
    byp_dst_reg = '0;
    byp_val     = '0;
  endtask

  task automatic issue(input int s1, input int s2, input int d, input int op);
    iss_valid    = 1'b1;
    iss_src1_reg = PW'(s1);
    iss_src2_reg = PW'(s2);
    iss_dst_reg  = PW'(d);
    iss_op       = OW'(op);
  endtask

  // Inputs are already driven; check the combinational side, advance the model, then the edge.
  task automatic cycle();
    bit   exp_rdy, acc, pop, rst_edge;
    uop_t n;
    #1;
    exp_rdy = rst && (q.size() < 2);
    chk("iss_ready", iss_ready, exp_rdy);
    chk("rf_src1_reg", rf_src1_reg, iss_src1_reg);
    chk("rf_src2_reg", rf_src2_reg, iss_src2_reg);
    acc   = iss_valid && exp_rdy && !flush_en;
    pop   = (q.size() > 0) && ex_ready;
    n.s1  = iss_src1_reg;
    n.s2  = iss_src2_reg;
    n.dst = iss_dst_reg;
    n.op  = iss_op;
    n.v1  = model_val(iss_src1_reg, prf[iss_src1_reg]);
    n.v2  = model_val(iss_src2_reg, prf[iss_src2_reg]);
    foreach (q[i]) begin
      q[i].v1 = model_val(q[i].s1, q[i].v1);
      q[i].v2 = model_val(q[i].s2, q[i].v2);
    end
    rst_edge = !rst;
    if (!rst || flush_en) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(n);
    end
    @(posedge clk);
    #1;
    chk("ex_valid", ex_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("ex_src1_val", ex_src1_val, q[0].v1);
      chk("ex_src2_val", ex_src2_val, q[0].v2);
      chk("ex_dst_reg", ex_dst_reg, q[0].dst);
      chk("ex_op", ex_op, q[0].op);
    end else if (rst_edge) begin
      chk("rst_src1_val", ex_src1_val, 0);
      chk("rst_src2_val", ex_src2_val, 0);
      chk("rst_dst_reg", ex_dst_reg, 0);
      chk("rst_op", ex_op, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) prf[i] = 32'h0;
    rst = 1'b0;
    ex_ready = 1'b0;
    iss_src1_reg = '0; iss_src2_reg = '0; iss_dst_reg = '0; iss_op = '0;
    idle();
    @(posedge clk);
    #1;

    // reset held, then release
    repeat (3) cycle();
    rst = 1'b1;
    cycle();

    // basic PRF read
    prf[5] = 32'h11;
    prf[9] = 32'h22;
    ex_ready = 1'b1;
    issue(5, 9, 12, 'hA5);
    cycle();
    idle();
    cycle();

    // bypass priority (k0 beats k1) and p0 immunity
    issue(5, 0, 3, 'h1);
    byp_valid   = 3'b011;
    byp_dst_reg = {6'd0, 6'd5, 6'd5};
    byp_val     = {32'h0, 32'hBB, 32'hAA};
    cycle();
    issue(0, 0, 4, 'h2);
    byp_valid   = 3'b001;
    byp_dst_reg = {6'd0, 6'd0, 6'd0};
    byp_val     = {32'h0, 32'h0, 32'h55};
    cycle();
    idle();
    cycle();

    // stall, fill both entries, snoop while waiting, then drain in order
    ex_ready = 1'b0;
    prf[7] = 32'h1;
    issue(7, 9, 1, 'hA);
    cycle();
    issue(9, 7, 2, 'hB);
    cycle();
    issue(3, 3, 3, 'hC);
    cycle();
    idle();
    byp_valid = 3'b100;
    byp_dst_reg[12 +: 6] = 6'd7;
    byp_val[64 +: 32]    = 32'h77;
    cycle();
    idle();
    ex_ready = 1'b1;
    repeat (3) cycle();

    // back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      issue(i + 1, i + 2, i, 100 + i);
      cycle();
    end
    idle();
    repeat (2) cycle();

    // flush while full, with an offered uop in the same cycle
    ex_ready = 1'b0;
    issue(5, 9, 20, 'h20);
    cycle();
    issue(9, 5, 21, 'h21);
    cycle();
    issue(7, 7, 22, 'h22);
    flush_en = 1'b1;
    cycle();
    idle();
    cycle();

    // random traffic, with occasional flush and mid-operation reset
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 199) != 0);
      flush_en     = ($urandom_range(0, 49) == 0);
      iss_valid    = ($urandom_range(0, 3) != 0);
      iss_src1_reg = PW'($urandom_range(0, 7));
      iss_src2_reg = PW'($urandom_range(0, 7));
      iss_dst_reg  = PW'($urandom_range(0, NP - 1));
      iss_op       = $urandom;
      ex_ready     = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < NB; k++) begin
        byp_valid[k]             = ($urandom_range(0, 2) == 0);
        byp_dst_reg[k*PW +: PW]  = PW'($urandom_range(0, 7));
        byp_val[k*32 +: 32]      = $urandom;
      end
      cycle();
      if ($urandom_range(0, 3) == 0) prf[$urandom_range(1, 7)] = $urandom;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
